// File: rtl/uart_retry_pkg.sv
// Shared state encoding and default parameters for the UART receive-side retry controller.
// No logic here: latency n/a, backpressure n/a.
package uart_retry_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'b00,
        ST_WAIT_RESEND = 2'b01,
        ST_HOLD        = 2'b10,
        ST_ERROR       = 2'b11
    } state_t;

    localparam int DEF_DATA_W         = 8;
    localparam int DEF_MAX_RETRIES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/uart_timeout_timer.sv
// Saturating silence timer; expired is high once the count reaches TIMEOUT_CYCLES-1.
// Latency: registered count, expired decoded from it; no backpressure (clear wins over enable).
module uart_timeout_timer
    import uart_retry_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count;

    // Stops at LAST so a stalled controller can never see the timer wrap back to zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/uart_retry_ctrl.sv
// Holds good frames until ack, requests resends on parity error or silence, errors after MAX_RETRIES.
// Latency: all outputs registered, one cycle after the causing edge; frames arriving in HOLD/ERROR are dropped with overrun.
module uart_retry_ctrl
    import uart_retry_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               frame_valid,
    input  logic [DATA_W-1:0]                  frame_data,
    input  logic                               parity_error,
    input  logic                               ack,
    output logic                               valid,
    output logic [DATA_W-1:0]                  data_out,
    output logic                               request_resend,
    output logic                               error,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic                               overrun
);

    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam logic [RW-1:0] CNT_MAX = RW'(MAX_RETRIES);

    state_t state_q, state_d;

    logic timer_expired;
    logic timer_clear;
    logic timer_enable;
    logic retry_evt;
    logic latch_en;
    logic resend_d;
    logic overrun_d;
    logic cnt_inc;
    logic cnt_clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        latch_en  = 1'b0;
        retry_evt = 1'b0;
        overrun_d = 1'b0;
        cnt_clr   = 1'b0;
        resend_d  = 1'b0;
        cnt_inc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_valid) begin
                    if (parity_error) begin
                        retry_evt = 1'b1;
                    end else begin
                        latch_en = 1'b1;
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_WAIT_RESEND: begin
                // A frame on the expiry cycle is handled as a frame, not as a timeout.
                if (frame_valid) begin
                    if (parity_error) begin
                        retry_evt = 1'b1;
                    end else begin
                        latch_en = 1'b1;
                        state_d  = ST_HOLD;
                    end
                end else if (timer_expired) begin
                    retry_evt = 1'b1;
                end
            end
            ST_HOLD, ST_ERROR: begin
                overrun_d = frame_valid;
                if (ack) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (retry_evt) begin
            if (retry_cnt < CNT_MAX) begin
                resend_d = 1'b1;
                cnt_inc  = 1'b1;
                state_d  = ST_WAIT_RESEND;
            end else begin
                state_d = ST_ERROR;
            end
        end
    end

    always_comb begin
        valid = (state_q == ST_HOLD);
        error = (state_q == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out       <= '0;
            retry_cnt      <= '0;
            request_resend <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            request_resend <= resend_d;
            overrun        <= overrun_d;
            if (latch_en) begin
                data_out <= frame_data;
            end
            if (cnt_clr) begin
                retry_cnt <= '0;
            end else if (cnt_inc) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
        end
    end

    // Restart the silence window on every retry and whenever we are not waiting for a resend.
    assign timer_enable = (state_q == ST_WAIT_RESEND);
    assign timer_clear  = retry_evt || (state_q != ST_WAIT_RESEND);

    uart_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

endmodule

// File: tb/tb_uart_retry_ctrl.sv
// Directed bench for uart_retry_ctrl at default parameters (DATA_W=8, MAX_RETRIES=2, TIMEOUT_CYCLES=16).
// Inputs change 1ns after a rising edge; outputs are sampled at the same point, after the edge that caused them.
module tb_uart_retry_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_valid;
    logic [7:0] frame_data;
    logic       parity_error;
    logic       ack;
    logic       valid;
    logic [7:0] data_out;
    logic       request_resend;
    logic       error;
    logic [1:0] retry_cnt;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int pulses;

    uart_retry_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .frame_valid   (frame_valid),
        .frame_data    (frame_data),
        .parity_error  (parity_error),
        .ack           (ack),
        .valid         (valid),
        .data_out      (data_out),
        .request_resend(request_resend),
        .error         (error),
        .retry_cnt     (retry_cnt),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic v, input logic chk_d, input logic [7:0] d,
                               input logic rr, input logic e, input logic [1:0] c, input logic ov);
        checks++;
        assert (valid === v) else begin
            errors++;
            $error("FAIL %s.valid observed=%0h expected=%0h", tag, valid, v);
        end
        if (chk_d) begin
            checks++;
            assert (data_out === d) else begin
                errors++;
                $error("FAIL %s.data_out observed=%0h expected=%0h", tag, data_out, d);
            end
        end
        checks++;
        assert (request_resend === rr) else begin
            errors++;
            $error("FAIL %s.request_resend observed=%0h expected=%0h", tag, request_resend, rr);
        end
        checks++;
        assert (error === e) else begin
            errors++;
            $error("FAIL %s.error observed=%0h expected=%0h", tag, error, e);
        end
        checks++;
        assert (retry_cnt === c) else begin
            errors++;
            $error("FAIL %s.retry_cnt observed=%0h expected=%0h", tag, retry_cnt, c);
        end
        checks++;
        assert (overrun === ov) else begin
            errors++;
            $error("FAIL %s.overrun observed=%0h expected=%0h", tag, overrun, ov);
        end
    endtask

    task automatic check_count(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Idle for n cycles with no frames, counting resend pulses seen.
    task automatic idle_cycles(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (request_resend === 1'b1) seen++;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pe);
        frame_valid  = 1'b1;
        frame_data   = d;
        parity_error = pe;
    endtask

    task automatic no_frame();
        frame_valid  = 1'b0;
        frame_data   = 8'h00;
        parity_error = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ack   = 1'b0;
        no_frame();
        tick();
        tick();
        check_state("reset", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
        reset = 1'b0;

        // Good frame, overrun in HOLD, ack release
        send(8'hA5, 1'b0);
        tick();
        check_state("good_a5", 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 2'd0, 1'b0);
        send(8'h11, 1'b0);
        tick();
        check_state("hold_overrun", 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 2'd0, 1'b1);
        no_frame();
        tick();
        check_state("hold_quiet", 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 2'd0, 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_state("ack_release", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);

        // Bad frame then good resend within 5 cycles
        send(8'hFF, 1'b1);
        tick();
        check_state("bad_first", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 1'b0);
        no_frame();
        tick();
        check_state("resend_one_cycle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 1'b0);
        tick();
        send(8'h3C, 1'b0);
        tick();
        check_state("good_3c", 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 2'd1, 1'b0);
        no_frame();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_state("ack_clr_cnt", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);

        // Bad frame then silence: resends at +1 and +17, error at +33
        send(8'h00, 1'b1);
        tick();
        check_state("silence_p1", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 1'b0);
        no_frame();
        idle_cycles(15, pulses);
        check_count("silence_gap1_pulses", pulses, 0);
        tick();
        check_state("silence_p17", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd2, 1'b0);
        idle_cycles(15, pulses);
        check_count("silence_gap2_pulses", pulses, 0);
        check_state("silence_p32", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd2, 1'b0);
        tick();
        check_state("silence_p33_err", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 1'b0);
        tick();
        check_state("error_sticky", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 1'b0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_state("error_ack", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);

        // Frame on exact expiry cycle wins over the timeout; ack in WAIT_RESEND ignored
        send(8'h00, 1'b1);
        tick();
        check_state("expiry_bad", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 1'b0);
        no_frame();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_state("ack_in_wait", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 1'b0);
        idle_cycles(14, pulses);
        check_count("expiry_gap_pulses", pulses, 0);
        send(8'h5A, 1'b0);
        tick();
        check_state("expiry_frame", 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 2'd1, 1'b0);
        no_frame();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_state("expiry_ack", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);

        // Three consecutive bad frames exhaust budget; fourth frame overruns
        send(8'h01, 1'b1);
        tick();
        check_state("bad3_1", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 1'b0);
        tick();
        check_state("bad3_2", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd2, 1'b0);
        tick();
        check_state("bad3_3_err", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 1'b0);
        tick();
        check_state("err_overrun", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd2, 1'b1);
        no_frame();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_state("bad3_ack", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);

        // Reset in WAIT_RESEND: nothing pending afterwards
        send(8'h00, 1'b1);
        tick();
        no_frame();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_state("reset_wait", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
        idle_cycles(20, pulses);
        check_count("reset_wait_no_pending", pulses, 0);
        send(8'h77, 1'b0);
        tick();
        check_state("post_reset_good", 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 2'd0, 1'b0);

        // Reset in HOLD clears latched data
        no_frame();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_state("reset_hold", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 1'b0);
        send(8'h99, 1'b0);
        tick();
        no_frame();
        check_state("post_reset_good2", 1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 2'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
